// File: rtl/mem_beat_unit_pkg.sv
// Shared types, funct3 codes and decode helpers for the memory-stage beat sequencer.
package mem_defines;

  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2, DWORD = 2'd3} mem_size_t;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_R = 2'd2, DONE = 2'd3} mbu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  function automatic mem_size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return BYTE;
      F3_LH, F3_LHU: return HALF;
      F3_LW, F3_LWU: return WORD;
      default:       return DWORD;
    endcase
  endfunction

  // Doubleword accesses and LWU only exist on a 64-bit core; stores have no unsigned forms.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3, input int xlen);
    if (we) return (f3[2] == 1'b0) && (xlen == 64 || f3 != F3_SD);
    return (f3 != 3'b111) && (xlen == 64 || (f3 != F3_LD && f3 != F3_LWU));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store data/byte-enables for one beat, and load shift plus extension.
module mem_lane_align
  import mem_defines::*;
#(
  parameter int XLEN  = 32,
  parameter int BUS_W = 16,
  parameter int OFFW  = 1
) (
  input  mem_size_t            st_size,
  input  logic [OFFW-1:0]      st_off,
  input  logic [XLEN-1:0]      st_data,
  input  logic [3:0]           st_beat,
  output logic [BUS_W-1:0]     st_wdata,
  output logic [BUS_W/8-1:0]   st_be,
  input  logic [2:0]           ld_op,
  input  logic [OFFW-1:0]      ld_off,
  input  logic [XLEN-1:0]      ld_asm,
  output logic [XLEN-1:0]      ld_data
);

  localparam int BB  = BUS_W / 8;
  localparam int WW  = XLEN + BUS_W;
  localparam int SHW = $clog2(XLEN);

  function automatic logic [XLEN-1:0] size_mask(input mem_size_t sz);
    case (sz)
      BYTE:    return XLEN'(8'hFF);
      HALF:    return XLEN'(16'hFFFF);
      WORD:    return XLEN'(32'hFFFF_FFFF);
      default: return '1;
    endcase
  endfunction

  function automatic logic [15:0] byte_mask(input mem_size_t sz);
    case (sz)
      BYTE:    return 16'h0001;
      HALF:    return 16'h0003;
      WORD:    return 16'h000F;
      default: return 16'h00FF;
    endcase
  endfunction

  logic [WW-1:0]   st_wide;
  logic [15:0]     be_wide;
  logic [XLEN-1:0] ld_shift;
  logic [XLEN-1:0] ld_mask;
  logic [SHW-1:0]  sign_idx;
  logic            sign_fill;

  // Offset is only non-zero for sub-beat accesses, so one shift pair covers both cases.
  always_comb begin
    st_wide  = (WW'(st_data & size_mask(st_size)) << {st_off, 3'b000}) >> (int'(st_beat) * BUS_W);
    st_wdata = st_wide[BUS_W-1:0];
    be_wide  = (byte_mask(st_size) << st_off) >> (int'(st_beat) * BB);
    st_be    = be_wide[BB-1:0];
  end

  always_comb begin
    ld_shift  = ld_asm >> {ld_off, 3'b000};
    ld_mask   = size_mask(f3_size(ld_op));
    sign_idx  = SHW'((8 << f3_size(ld_op)) - 1);
    sign_fill = ~ld_op[2] & ld_shift[sign_idx];
    ld_data   = (ld_shift & ld_mask) | (sign_fill ? ~ld_mask : '0);
  end

endmodule

// File: rtl/mem_beat_unit.sv
// MEM-stage load/store sequencer: splits one request into narrow bus beats and reassembles loads.
// Handshakes: a transfer happens on a rising edge where valid && ready; payload holds while valid && !ready.
module mem_beat_unit
  import mem_defines::*;
#(
  parameter int XLEN   = 32,
  parameter int BUS_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_done,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_op,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  input  logic [XLEN-1:0]      req_fwd_data,
  input  logic                 req_fwd_sel,
  output logic [XLEN-1:0]      resp_data,
  output logic                 done,
  output logic                 err_misaligned,
  output logic                 bus_valid,
  input  logic                 bus_ready,
  output logic                 bus_we,
  output logic [ADDR_W-1:0]    bus_addr,
  output logic [BUS_W-1:0]     bus_wdata,
  output logic [BUS_W/8-1:0]   bus_be,
  input  logic                 bus_rvalid,
  input  logic [BUS_W-1:0]     bus_rdata,
  output logic [1:0]           dbg_state
);

  localparam int BB   = BUS_W / 8;
  localparam int OFFW = (BB > 1) ? $clog2(BB) : 1;
  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(BB - 1);

  mbu_state_t      state;
  logic [3:0]      k;
  logic [2:0]      op;
  logic            we;
  logic [OFFW-1:0] off;
  logic [XLEN-1:0] st_data;
  logic [XLEN-1:0] asm_q;

  logic [XLEN-1:0]    req_data, la_data, asm_next, ld_data;
  logic [OFFW-1:0]    req_off, la_off;
  logic [ADDR_W-1:0]  req_base;
  logic [2:0]         amask;
  logic               req_ok;
  mem_size_t          la_size;
  logic [3:0]         la_beat, k_last;
  logic [BUS_W-1:0]   la_wdata;
  logic [BB-1:0]      la_be;
  int                 bits;

  always_comb begin
    req_data = req_fwd_sel ? req_fwd_data : req_wdata;
    req_off  = req_addr[OFFW-1:0] & OFFW'(BB - 1);
    req_base = req_addr & ~LANE_MASK;
    amask    = 3'((4'd1 << f3_size(req_op)) - 4'd1);
    req_ok   = f3_legal(req_we, req_op, XLEN) && ((req_addr[2:0] & amask) == 3'd0);
    bits     = 8 << f3_size(op);
    k_last   = (bits > BUS_W) ? 4'(bits / BUS_W - 1) : 4'd0;
    asm_next = asm_q | (XLEN'(bus_rdata) << (int'(k) * BUS_W));
  end

  // Lane logic looks at the incoming request while idle, otherwise at the beat about to be issued.
  always_comb begin
    if (state == IDLE) begin
      la_size = f3_size(req_op);
      la_off  = req_off;
      la_data = req_data;
      la_beat = 4'd0;
    end else begin
      la_size = f3_size(op);
      la_off  = off;
      la_data = st_data;
      la_beat = k + 4'd1;
    end
  end

  mem_lane_align #(.XLEN(XLEN), .BUS_W(BUS_W), .OFFW(OFFW)) u_align (
    .st_size  (la_size),
    .st_off   (la_off),
    .st_data  (la_data),
    .st_beat  (la_beat),
    .st_wdata (la_wdata),
    .st_be    (la_be),
    .ld_op    (op),
    .ld_off   (off),
    .ld_asm   (asm_next),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      k              <= '0;
      op             <= '0;
      we             <= 1'b0;
      off            <= '0;
      st_data        <= '0;
      asm_q          <= '0;
      req_ready      <= 1'b0;
      done           <= 1'b0;
      err_misaligned <= 1'b0;
      bus_valid      <= 1'b0;
      bus_we         <= 1'b0;
      bus_addr       <= '0;
      bus_wdata      <= '0;
      bus_be         <= '0;
      resp_data      <= '0;
    end else begin
      done           <= 1'b0;
      err_misaligned <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= init_done;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            op        <= req_op;
            we        <= req_we;
            off       <= req_off;
            st_data   <= req_data;
            k         <= '0;
            asm_q     <= '0;
            if (!req_ok) begin
              state          <= DONE;
              done           <= 1'b1;
              err_misaligned <= 1'b1;
              resp_data      <= '0;
            end else begin
              state     <= ISSUE;
              bus_valid <= 1'b1;
              bus_we    <= req_we;
              bus_addr  <= req_base;
              bus_wdata <= req_we ? la_wdata : '0;
              bus_be    <= la_be;
            end
          end
        end
        ISSUE: begin
          if (bus_ready) begin
            if (we) begin
              if (k == k_last) begin
                state     <= DONE;
                bus_valid <= 1'b0;
                done      <= 1'b1;
                resp_data <= '0;
              end else begin
                k         <= k + 4'd1;
                bus_addr  <= bus_addr + ADDR_W'(BB);
                bus_wdata <= la_wdata;
                bus_be    <= la_be;
              end
            end else begin
              state     <= WAIT_R;
              bus_valid <= 1'b0;
            end
          end
        end
        WAIT_R: begin
          if (bus_rvalid) begin
            asm_q <= asm_next;
            if (k == k_last) begin
              state     <= DONE;
              done      <= 1'b1;
              resp_data <= ld_data;
            end else begin
              k         <= k + 4'd1;
              state     <= ISSUE;
              bus_valid <= 1'b1;
              bus_addr  <= bus_addr + ADDR_W'(BB);
              bus_be    <= la_be;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          req_ready <= init_done;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_mem_beat_unit.sv
// Self-checking bench for mem_beat_unit (XLEN=32, BUS_W=16) with a byte-array bus responder.
module tb_mem_beat_unit;

  logic        clk = 1'b0;
  logic        rst, init_done, req_valid, req_ready, req_we, req_fwd_sel;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata, req_fwd_data, resp_data, bus_addr;
  logic        done, err_misaligned, bus_valid, bus_ready, bus_we, bus_rvalid;
  logic [15:0] bus_wdata, bus_rdata;
  logic [1:0]  bus_be, dbg_state;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:1023];
  logic [50:0] beat_q[$];   // {we, addr, wdata, be}
  logic [32:0] resp_q[$];   // {err, data}

  bit          rand_ready = 0, rand_rd = 0, rd_hold = 0, spur_en = 0, rd_pend = 0;
  int          rd_wait = 0;
  logic [15:0] rd_data;

  mem_beat_unit dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_fwd_data(req_fwd_data),
    .req_fwd_sel(req_fwd_sel), .resp_data(resp_data), .done(done),
    .err_misaligned(err_misaligned), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit op_legal(input bit we, input logic [2:0] op, input logic [31:0] addr);
    int s;
    s = 1 << op[1:0];
    if (we && op[2]) return 0;
    if (op == 3'b011 || op == 3'b110 || op == 3'b111) return 0;
    return (int'(addr[2:0]) % s) == 0;
  endfunction

  // Reference model: byte-by-byte placement on a 2-byte bus, load value read from the array.
  task automatic push_expect(input bit we, input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] data);
    int s, n, off, idx;
    logic [31:0] base, val;
    logic [15:0] wd;
    logic [1:0]  be;
    if (!op_legal(we, op, addr)) begin
      resp_q.push_back({1'b1, 32'h0});
      return;
    end
    s    = 1 << op[1:0];
    n    = (s * 8 > 16) ? s * 8 / 16 : 1;
    base = addr & ~32'h1;
    off  = int'(addr[0]);
    for (int k = 0; k < n; k++) begin
      wd = '0;
      be = '0;
      for (int j = 0; j < 2; j++) begin
        idx = 2 * k + j - off;
        if (idx >= 0 && idx < s) begin
          be[j] = 1'b1;
          if (we) wd[8*j +: 8] = data[8*idx +: 8];
        end
      end
      beat_q.push_back({we, base + 32'(2 * k), wd, be});
    end
    if (we) begin
      resp_q.push_back({1'b0, 32'h0});
    end else begin
      val = '0;
      for (int i = 0; i < s; i++) val[8*i +: 8] = mem[(addr[9:0] + 10'(i))];
      if (!op[2] && s < 4 && val[8*s-1]) val = val | ~((32'd1 << (8 * s)) - 32'd1);
      resp_q.push_back({1'b0, val});
    end
  endtask

  task automatic start_req(input bit we, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] fwd, input bit fsel);
    int w;
    push_expect(we, op, addr, fsel ? fwd : wd);
    req_valid = 1'b1; req_we = we; req_op = op; req_addr = addr;
    req_wdata = wd; req_fwd_data = fwd; req_fwd_sel = fsel;
    w = 0;
    while (req_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (req_ready !== 1'b1) chk("accept_timeout", 1, 0);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic finish_req(input int exp_lat);
    int lat;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) chk("done_timeout", 1, 0);
    else if (exp_lat >= 0) chk("latency", lat, exp_lat);
    @(negedge clk);
  endtask

  task automatic do_req(input bit we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] fwd, input bit fsel,
                        input int exp_lat);
    start_req(we, op, addr, wd, fwd, fsel);
    finish_req(exp_lat);
  endtask

  // Bus responder and output scoreboard.
  initial begin : responder
    logic [50:0] got_b;
    logic [15:0] m;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    forever begin
      @(negedge clk);
      bus_rvalid = 1'b0;
      if (rd_pend && !rd_hold) begin
        if (rd_wait == 0) begin
          bus_rvalid = 1'b1;
          bus_rdata  = rd_data;
          rd_pend    = 0;
        end else begin
          rd_wait--;
        end
      end else if (!rd_pend && spur_en && dbg_state != 2'd2 && $urandom_range(0, 7) == 0) begin
        bus_rvalid = 1'b1;
        bus_rdata  = 16'($urandom);
      end
      if (done === 1'b1) begin
        if (resp_q.size() == 0) chk("done_extra", 1, 0);
        else chk("resp", {err_misaligned, resp_data}, resp_q.pop_front());
      end
      bus_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus_valid === 1'b1 && bus_ready) begin
        m     = {{8{bus_be[1]}}, {8{bus_be[0]}}};
        got_b = {bus_we, bus_addr, bus_we ? (bus_wdata & m) : 16'h0, bus_be};
        if (beat_q.size() == 0) chk("beat_extra", 1, 0);
        else chk("beat", got_b, beat_q.pop_front());
        if (bus_we) begin
          for (int j = 0; j < 2; j++)
            if (bus_be[j]) mem[bus_addr[9:0] + 10'(j)] = bus_wdata[8*j +: 8];
        end else begin
          rd_pend = 1;
          rd_data = {mem[bus_addr[9:0] + 10'd1], mem[bus_addr[9:0]]};
          rd_wait = rand_rd ? $urandom_range(0, 2) : 0;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [3:0] tbl [8];
    logic [3:0] pick;
    logic [31:0] addr;
    int w, s;
    tbl = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1010};
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    mem[10'h202] = 8'hAA;
    mem[10'h203] = 8'h80;

    // Reset values
    rst = 1'b1; init_done = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_op = 3'b010;
    req_addr = '0; req_wdata = '0; req_fwd_data = '0; req_fwd_sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_ready", req_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_misaligned, 0);
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    chk("rst_bus_be", bus_be, 0);
    chk("rst_resp", resp_data, 0);
    rst = 1'b0;

    // Init gate
    req_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("ready_no_init", req_ready, 0);
    end
    req_valid = 1'b0;
    init_done = 1'b1;
    @(negedge clk);
    chk("ready_after_init", req_ready, 1);

    // SW 0xDEADBEEF to 0x100: beats 0x100/BEEF, 0x102/DEAD, done in cycle 3
    do_req(1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 3);
    // LB / LBU from 0x203 with beat 0x202 returning 0x80AA
    do_req(0, 3'b000, 32'h203, 32'h0, 32'h0, 0, 3);
    chk("lb_value", resp_data, 32'hFFFF_FF80);
    do_req(0, 3'b100, 32'h203, 32'h0, 32'h0, 0, 3);
    chk("lbu_value", resp_data, 32'h0000_0080);

    // Reset while waiting on the first read beat of an LW
    rd_hold = 1;
    start_req(0, 3'b010, 32'h40, 32'h0, 32'h0, 0);
    w = 0;
    while (dbg_state !== 2'd2 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("reach_wait_r", dbg_state, 2'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd_hold = 0;
    beat_q.delete();
    resp_q.delete();
    chk("midrst_state", dbg_state, 2'd0);
    chk("midrst_resp", resp_data, 0);
    chk("midrst_bus_valid", bus_valid, 0);
    repeat (6) begin
      @(negedge clk);
      chk("midrst_no_done", done, 0);
      chk("midrst_idle", dbg_state, 2'd0);
    end
    chk("midrst_resp_after", resp_data, 0);

    // SH with forwarded data
    do_req(1, 3'b001, 32'h10, 32'hFFFF, 32'h1234, 1, 2);
    do_req(1, 3'b000, 32'h21, 32'h77, 32'h0, 0, 2);
    do_req(0, 3'b101, 32'h10, 32'h0, 32'h0, 0, 3);
    chk("lhu_fwd_value", resp_data, 32'h1234);

    // Illegal requests: no bus traffic, done plus error in cycle 1
    do_req(0, 3'b010, 32'h6, 32'h0, 32'h0, 0, 1);
    do_req(0, 3'b011, 32'h8, 32'h0, 32'h0, 0, 1);
    do_req(0, 3'b111, 32'h8, 32'h0, 32'h0, 0, 1);
    do_req(1, 3'b100, 32'h8, 32'h5, 32'h0, 0, 1);
    do_req(1, 3'b001, 32'h11, 32'h5, 32'h0, 0, 1);
    do_req(0, 3'b010, 32'h40, 32'h0, 32'h0, 0, 5);

    // Random traffic with stalls, variable read latency and stray rvalid pulses
    rand_ready = 1; rand_rd = 1; spur_en = 1;
    repeat (60) begin
      pick = tbl[$urandom_range(0, 7)];
      s    = 1 << pick[1:0];
      addr = 32'($urandom_range(0, 1000));
      if ($urandom_range(0, 4) != 0) addr = addr & ~32'(s - 1);
      do_req(pick[3], pick[2:0], addr, $urandom, $urandom, 1'($urandom_range(0, 1)), -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rand_ready = 0; rand_rd = 0; spur_en = 0;
    repeat (5) @(negedge clk);
    chk("beat_q_drained", beat_q.size(), 0);
    chk("resp_q_drained", resp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_beat_unit.md
# mem_beat_unit

Parametrised memory-stage load/store sequencer for the RISC-V pipeline. It accepts one load or store per handshake from the MEM stage and splits it into the number of narrow beats the backing bus needs; the 16-bit SDRAM controller is the default case. It also applies mem-to-mem forwarding to store data, reassembles and sign- or zero-extends load data, and reports a one-cycle `done`. It is the generalised successor of the fixed 32-over-16 memory stage, adding configurable widths, misalignment detection, and an init gate.

## Interface
- `XLEN`, default 32: core data width; legal values 32 and 64.
- `BUS_W`, default 16: backing bus data width; legal values 8, 16 and 32; must satisfy `BUS_W <= XLEN`.
- `ADDR_W`, default 32: address width.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `init_done` in 1: backing memory is initialised; requests are refused until it is high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_op` in 3: RISC-V funct3 (LB/LH/LW/LD/LBU/LHU/LWU; SB/SH/SW/SD).
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in XLEN: raw store data.
- `req_fwd_data` in XLEN: mem-to-mem forwarded store data.
- `req_fwd_sel` in 1: when 1, the store uses `req_fwd_data`.
- `resp_data` out XLEN: extended load result; zero for stores.
- `done` out 1: one-cycle completion pulse.
- `err_misaligned` out 1: pulses together with `done` for a misaligned or illegal op.
- `bus_valid` out 1; `bus_ready` in 1: beat handshake.
- `bus_we` out 1; `bus_addr` out ADDR_W; `bus_wdata` out BUS_W; `bus_be` out BUS_W/8: beat payload.
- `bus_rvalid` in 1; `bus_rdata` in BUS_W: read return data.

## Operation
- Access size S bytes is 1, 2, 4 or 8, decoded from `req_op`.
- Beat count N = max(1, 8*S/BUS_W).
- On accept (`req_valid && req_ready`) the unit captures addr, op, we, and store data. Store data is `req_fwd_data` when `req_fwd_sel` is 1, otherwise `req_wdata`.
- Misaligned (addr mod S != 0), or funct3 011/110 with XLEN=32, or any undefined funct3: the unit issues no bus traffic and goes directly to DONE with `err_misaligned` set.
- Beat k address = (addr aligned down to BUS_W/8) + k*BUS_W/8.
- `bus_be` marks only the bytes inside the access. Example: SB to addr offset 1 on a 16-bit bus gives `bus_be` = 2'b10.
- Store bytes are shifted into the beat lane matching the address offset. Beats are issued in ascending address order.
- Load beats land little-endian in an assembly register. The final value is shifted down by the offset, then sign-extended for LB/LH/LW or zero-extended for LBU/LHU/LWU.
- State machine:
  - IDLE: `req_ready` = `init_done`. On accept, go to ISSUE, or to DONE if the request is illegal.
  - ISSUE: `bus_valid` = 1. On `bus_ready`:
    - Store: when k = N-1 go to DONE, else increment k.
    - Load: go to WAIT_R.
  - WAIT_R: `bus_valid` = 0. On `bus_rvalid`, latch the lane; when k = N-1 go to DONE, else increment k and return to ISSUE.
  - DONE: `done` = 1 for one cycle, `resp_data` valid; then IDLE.
- Exactly one read is outstanding at a time. `bus_rvalid` outside WAIT_R is ignored.
- Reset values: state IDLE, k = 0. `req_ready`, `done`, `err_misaligned`, `bus_valid`, `bus_we` are all 0. `bus_addr`, `bus_wdata`, `bus_be`, `resp_data` are 0.
- Reset asserted mid-operation: all outputs return to reset values on the next edge. A late `bus_rvalid` is discarded. A partially written store is not rolled back.
- `init_done` falling while busy does not abort the current request; it only blocks new accepts.

## Timing
- Accept happens in cycle 0. `bus_valid` rises in cycle 1 (registered).
- `bus_addr`, `bus_wdata`, `bus_be`, `bus_we` are stable while `bus_valid` is high and `bus_ready` is low.
- Store latency with `bus_ready` always high is N+1 cycles to `done`. For SW with BUS_W=16, `done` is in cycle 3.
- `bus_rvalid` is legal no earlier than the cycle after the beat handshake. Load latency with 1-cycle read return is 2N+1.
- `req_ready` is low from the cycle after accept until the cycle after `done`. Back-to-back throughput is one request per N+2 cycles at best.
- An illegal request gives `done` in cycle 1.

## Structure
- The following live in `mem_defines`:
  - `mem_size_t` (BYTE/HALF/WORD/DWORD);
  - `mbu_state_t` (IDLE/ISSUE/WAIT_R/DONE);
  - funct3 localparams;
  - a function returning size from funct3.
- Sub-module `mem_lane_align` (combinational) computes store lane shift and `bus_be`, and load shift plus extension. It keeps the FSM file focused on sequencing.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, BUS_W=16, `bus_ready` = 1: beats at 0x100 wdata 0xBEEF be 2'b11, then 0x102 wdata 0xDEAD be 2'b11; `done` in cycle 3.
- LB addr 0x203, bus returns 0x80AA for beat at 0x202: `resp_data` = 0xFFFFFF80. The same stimulus with LBU gives 0x00000080.
- SH with `req_fwd_sel` = 1, fwd 0x1234, raw 0xFFFF, addr 0x10: beat wdata 0x1234, be 2'b11.
- LW addr 0x6: `done` and `err_misaligned` in cycle 1, `bus_valid` never asserted.
- `init_done` = 0 with `req_valid` = 1 for 5 cycles: `req_ready` stays 0. Raising `init_done` gives an accept the next cycle.
- `rst` asserted in WAIT_R of an LW, then `bus_rvalid` arrives: no `done`; state is IDLE and `resp_data` = 0.
